// File: rtl/ps2_kbd_decoder.sv
// PS/2 keyboard receiver: set-2 prefix folding, show-ahead event FIFO, distinct-key press counter.
// Optional partial-frame watchdog enabled by defining PS2_TIMEOUT_EN.
module ps2_kbd_decoder #(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned TIMEOUT_CYC = 20000
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             ps2_clk,
    input  logic             ps2_data,
    input  logic             rd_en,
    input  logic             clr_err,
    output logic             valid,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_brk,
    output logic             overflow,
    output logic             frame_err,
    output logic [CNT_W-1:0] press_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    logic [2:0] clk_sync_q, data_sync_q;
    logic       sample, bit_in;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clk_sync_q  <= 3'b111;
            data_sync_q <= 3'b111;
        end else begin
            clk_sync_q  <= {clk_sync_q[1:0], ps2_clk};
            data_sync_q <= {data_sync_q[1:0], ps2_data};
        end
    end

    assign sample = clk_sync_q[2] & ~clk_sync_q[1];
    assign bit_in = data_sync_q[2];

    logic timeout;

`ifdef PS2_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] to_cnt_q;
    state_e        to_state;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            to_cnt_q <= '0;
        end else if (sample || to_state == StIdle) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + TW'(1);
        end
    end

    assign timeout = (to_state == StShift) && !sample && (to_cnt_q == TW'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign timeout = 1'b0;
`endif

    state_e     state_q, state_d;
    logic [3:0] bit_idx_q, bit_idx_d;
    logic       start_q, start_d;
    logic [8:0] bits_q, bits_d;
    logic       frame_done;

`ifdef PS2_TIMEOUT_EN
    assign to_state = state_q;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StIdle;
            bit_idx_q <= 4'd0;
            start_q   <= 1'b0;
            bits_q    <= 9'd0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            start_q   <= start_d;
            bits_q    <= bits_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        start_d    = start_q;
        bits_d     = bits_q;
        frame_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (sample) begin
                    start_d   = bit_in;
                    bit_idx_d = 4'd1;
                    state_d   = StShift;
                end
            end
            StShift: begin
                if (timeout) begin
                    state_d   = StIdle;
                    bit_idx_d = 4'd0;
                end else if (sample) begin
                    if (bit_idx_q == 4'd10) begin
                        frame_done = 1'b1;
                        state_d    = StIdle;
                        bit_idx_d  = 4'd0;
                    end else begin
                        bits_d[bit_idx_q - 4'd1] = bit_in;
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Stop bit is the live sample; bits_q holds data[7:0] and parity.
    logic       frame_ok, byte_ok, frame_bad, push;
    logic [7:0] byte_in;

    assign byte_in   = bits_q[7:0];
    assign frame_ok  = ~start_q & bit_in & (^bits_q);
    assign byte_ok   = frame_done & frame_ok;
    assign frame_bad = frame_done & ~frame_ok;
    assign push      = byte_ok && (byte_in != 8'hE0) && (byte_in != 8'hF0);

    logic             ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
    logic [8:0]       last_make_q, last_make_d;
    logic [CNT_W-1:0] press_q, press_d;
    logic [8:0]       key;

    assign key = {ext_pend_q, byte_in};

    always_comb begin
        ext_pend_d  = ext_pend_q;
        brk_pend_d  = brk_pend_q;
        last_make_d = last_make_q;
        press_d     = press_q;
        if (frame_bad || timeout) begin
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
        end else if (byte_ok) begin
            if (byte_in == 8'hE0) begin
                ext_pend_d = 1'b1;
            end else if (byte_in == 8'hF0) begin
                brk_pend_d = 1'b1;
            end else begin
                ext_pend_d = 1'b0;
                brk_pend_d = 1'b0;
            end
        end
        if (push) begin
            if (!brk_pend_q) begin
                if (key != last_make_q) begin
                    press_d     = press_q + CNT_W'(1);
                    last_make_d = key;
                end
            end else if (key == last_make_q) begin
                last_make_d = 9'h000;
            end
        end
    end

    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          pop, full, push_ok, ovf_set;
    logic          ovf_q, ferr_q;

    assign valid   = (cnt_q != '0);
    assign full    = (cnt_q == (AW + 1)'(FIFO_DEPTH));
    assign pop     = rd_en & valid;
    assign push_ok = push & (~full | pop);
    assign ovf_set = push & full & ~pop;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + (AW + 1)'(1);
            2'b01:   cnt_d = cnt_q - (AW + 1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= {ext_pend_q, brk_pend_q, byte_in};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ext_pend_q  <= 1'b0;
            brk_pend_q  <= 1'b0;
            last_make_q <= 9'h000;
            press_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            ext_pend_q  <= ext_pend_d;
            brk_pend_q  <= brk_pend_d;
            last_make_q <= last_make_d;
            press_q     <= press_d;
            cnt_q       <= cnt_d;
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
            // A new error in the same cycle as clr_err wins.
            if (ovf_set)      ovf_q <= 1'b1;
            else if (clr_err) ovf_q <= 1'b0;
            if (frame_bad || timeout) ferr_q <= 1'b1;
            else if (clr_err)         ferr_q <= 1'b0;
        end
    end

    assign key_code    = valid ? mem[rd_ptr_q][7:0] : 8'h00;
    assign key_brk     = valid ? mem[rd_ptr_q][8] : 1'b0;
    assign key_ext     = valid ? mem[rd_ptr_q][9] : 1'b0;
    assign overflow    = ovf_q;
    assign frame_err   = ferr_q;
    assign press_count = press_q;

endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// Self-checking bench for ps2_kbd_decoder: directed vector table, FIFO corner sequences,
// and randomized byte streams checked against a queue-based event model.
`timescale 1ns/1ps
module tb_ps2_kbd_decoder;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned TOC   = 300;
    localparam int          HALF  = 8;

    logic       clk = 1'b0;
    logic       resetn, ps2_clk, ps2_data, rd_en, clr_err;
    logic       valid, key_ext, key_brk, overflow, frame_err;
    logic [7:0] key_code, press_count;

    ps2_kbd_decoder #(
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (8),
        .TIMEOUT_CYC(TOC)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rd_en      (rd_en),
        .clr_err    (clr_err),
        .valid      (valid),
        .key_code   (key_code),
        .key_ext    (key_ext),
        .key_brk    (key_brk),
        .overflow   (overflow),
        .frame_err  (frame_err),
        .press_count(press_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: events as records in a bounded queue, plus sticky flags.
    typedef struct packed {logic ext; logic brk; logic [7:0] code;} ev_t;
    ev_t        mq[$];
    bit         m_ext, m_brk, m_ferr, m_ovf;
    logic [8:0] m_last;
    logic [7:0] m_cnt;

    function automatic void model_reset();
        mq.delete();
        m_ext = 0; m_brk = 0; m_ferr = 0; m_ovf = 0;
        m_last = 9'h000; m_cnt = 8'd0;
    endfunction

    function automatic void model_byte(input logic [7:0] b, input bit bad);
        ev_t e;
        if (bad) begin
            m_ferr = 1; m_ext = 0; m_brk = 0;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            e = '{ext: m_ext, brk: m_brk, code: b};
            if (!m_brk && {m_ext, b} != m_last) begin
                m_cnt  = m_cnt + 8'd1;
                m_last = {m_ext, b};
            end else if (m_brk && {m_ext, b} == m_last) begin
                m_last = 9'h000;
            end
            if (mq.size() < DEPTH) mq.push_back(e);
            else m_ovf = 1;
            m_ext = 0; m_brk = 0;
        end
    endfunction

    task automatic check_model(input string name);
        check({name, ".valid"}, 32'(valid), 32'(mq.size() != 0));
        if (mq.size() != 0) check({name, ".head"}, 32'({key_ext, key_brk, key_code}), 32'(mq[0]));
        check({name, ".count"}, 32'(press_count), 32'(m_cnt));
        check({name, ".ferr"}, 32'(frame_err), 32'(m_ferr));
        check({name, ".ovf"}, 32'(overflow), 32'(m_ovf));
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad, input bit pop_at_stop);
        logic [10:0] f;
        f = {1'b1, ~(^b) ^ bad, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            @(negedge clk) ps2_data = f[i];
            repeat (HALF - 1) @(negedge clk);
            ps2_clk = 1'b0;
            if (i == 10 && pop_at_stop) begin
                // rd_en lands on the edge that writes the event.
                repeat (2) @(negedge clk);
                rd_en = 1'b1;
                @(negedge clk) rd_en = 1'b0;
                repeat (HALF - 3) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            ps2_clk = 1'b1;
        end
        repeat (4) @(negedge clk);
        model_byte(b, bad);
    endtask

    task automatic send_partial(input logic [7:0] b, input int nbits);
        logic [10:0] f;
        f = {1'b1, ~(^b), b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk) ps2_data = f[i];
            repeat (HALF - 1) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic pop_one(input string name);
        ev_t e;
        e = mq.pop_front();
        check({name, ".pop_head"}, 32'({key_ext, key_brk, key_code}), 32'(e));
        @(negedge clk) rd_en = 1'b1;
        @(negedge clk) rd_en = 1'b0;
    endtask

    task automatic do_clr();
        @(negedge clk) clr_err = 1'b1;
        @(negedge clk) clr_err = 1'b0;
        m_ferr = 0; m_ovf = 0;
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, ".valid"}, 32'(valid), 32'd0);
        check({name, ".code"}, 32'(key_code), 32'd0);
        check({name, ".ext"}, 32'(key_ext), 32'd0);
        check({name, ".brk"}, 32'(key_brk), 32'd0);
        check({name, ".ovf"}, 32'(overflow), 32'd0);
        check({name, ".ferr"}, 32'(frame_err), 32'd0);
        check({name, ".count"}, 32'(press_count), 32'd0);
    endtask

    typedef struct {
        logic [7:0] data;
        bit         bad;
        bit         clr_after;
        bit         exp_valid;
        logic [7:0] exp_code;
        bit         exp_ext;
        bit         exp_brk;
        logic [7:0] exp_cnt;
        bit         exp_ferr;
    } vec_t;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[11];
        tbl[0]  = '{8'h1C, 0, 0, 1, 8'h1C, 0, 0, 8'd1, 0};
        tbl[1]  = '{8'hE0, 0, 0, 0, 8'h00, 0, 0, 8'd1, 0};
        tbl[2]  = '{8'hF0, 0, 0, 0, 8'h00, 0, 0, 8'd1, 0};
        tbl[3]  = '{8'h75, 0, 0, 1, 8'h75, 1, 1, 8'd1, 0};
        tbl[4]  = '{8'h1C, 0, 0, 1, 8'h1C, 0, 0, 8'd1, 0};
        tbl[5]  = '{8'h1C, 0, 0, 1, 8'h1C, 0, 0, 8'd1, 0};
        tbl[6]  = '{8'hF0, 0, 0, 0, 8'h00, 0, 0, 8'd1, 0};
        tbl[7]  = '{8'h1C, 0, 0, 1, 8'h1C, 0, 1, 8'd1, 0};
        tbl[8]  = '{8'h1C, 0, 0, 1, 8'h1C, 0, 0, 8'd2, 0};
        tbl[9]  = '{8'h55, 1, 1, 0, 8'h00, 0, 0, 8'd2, 1};
        tbl[10] = '{8'h32, 0, 0, 1, 8'h32, 0, 0, 8'd3, 0};

        resetn = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        resetn = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            send_frame(tbl[i].data, tbl[i].bad, 0);
            check({nm, ".valid"}, 32'(valid), 32'(tbl[i].exp_valid));
            if (tbl[i].exp_valid) begin
                check({nm, ".code"}, 32'(key_code), 32'(tbl[i].exp_code));
                check({nm, ".ext"}, 32'(key_ext), 32'(tbl[i].exp_ext));
                check({nm, ".brk"}, 32'(key_brk), 32'(tbl[i].exp_brk));
            end
            check({nm, ".count"}, 32'(press_count), 32'(tbl[i].exp_cnt));
            check({nm, ".ferr"}, 32'(frame_err), 32'(tbl[i].exp_ferr));
            if (tbl[i].exp_valid) begin
                pop_one(nm);
                check({nm, ".valid_after_pop"}, 32'(valid), 32'd0);
            end
            if (tbl[i].clr_after) begin
                do_clr();
                check({nm, ".ferr_after_clr"}, 32'(frame_err), 32'd0);
            end
        end

        // Overflow: DEPTH+1 events, no reads.
        for (int i = 0; i <= DEPTH; i++) send_frame(8'(8'h10 + i), 0, 0);
        check("ovf.valid", 32'(valid), 32'd1);
        check("ovf.flag", 32'(overflow), 32'd1);
        check_model("ovf");
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("ovf.order%0d", i), 32'(key_code), 32'(8'h10 + i));
            pop_one("ovf");
        end
        check("ovf.drained", 32'(valid), 32'd0);
        do_clr();

        // Full FIFO: push and pop in the same cycle.
        for (int i = 0; i < DEPTH; i++) send_frame(8'(8'h20 + i), 0, 0);
        check("full.ovf_before", 32'(overflow), 32'd0);
        void'(mq.pop_front());
        send_frame(8'h28, 0, 1);
        check("full.no_ovf", 32'(overflow), 32'd0);
        check("full.head", 32'(key_code), 32'h21);
        check_model("full");
        while (mq.size() != 0) pop_one("full");
        check("full.drained", 32'(valid), 32'd0);

`ifdef PS2_TIMEOUT_EN
        send_partial(8'h5A, 5);
        repeat (TOC + 10) @(negedge clk);
        m_ferr = 1; m_ext = 0; m_brk = 0;
        check("tmo.ferr", 32'(frame_err), 32'd1);
        send_frame(8'h1C, 0, 0);
        check("tmo.code", 32'(key_code), 32'h1C);
        check_model("tmo");
        while (mq.size() != 0) pop_one("tmo");
        do_clr();
`endif

        // Randomized byte stream against the model.
        for (int n = 0; n < 120; n++) begin
            logic [7:0] b;
            bit         bad;
            int         r;
            r = $urandom_range(0, 9);
            case (r)
                0:       b = 8'hE0;
                1:       b = 8'hF0;
                2:       b = 8'h1C;
                3:       b = 8'h32;
                4:       b = 8'h75;
                default: b = 8'($urandom_range(1, 8'h7F));
            endcase
            bad = ($urandom_range(0, 15) == 0);
            send_frame(b, bad, 0);
            check_model($sformatf("rnd%0d", n));
            r = $urandom_range(0, 2);
            for (int k = 0; k < r; k++) if (mq.size() != 0) pop_one("rnd");
            if ($urandom_range(0, 7) == 0) do_clr();
        end
        while (mq.size() != 0) pop_one("rnd_drain");

        // Reset in the middle of a frame discards it.
        send_partial(8'h44, 4);
        @(negedge clk) resetn = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        send_frame(8'h1C, 0, 0);
        check_model("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
